// File: rtl/r52_sequencer.sv
// Fetch/decode/execute controller for the R52 accumulator machine.
// Owns the program counter and instruction register, sequences each
// instruction through FETCH/DECODE/EXEC and drives the datapath strobes.
module r52_sequencer #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 12,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  timer555,
  input  logic                  reset_count_n,
  input  logic                  run,
  input  logic                  step_mode,
  input  logic                  step,
  output logic [ADDR_WIDTH-1:0] RAM1_addr,
  input  logic [DATA_WIDTH-1:0] RAM1_out,
  input  logic                  Z_flag,
  input  logic                  PZ_flag,
  output logic [ADDR_WIDTH-1:0] RAM2_addr,
  output logic                  RAM2_we,
  output logic [1:0]            mux_switch_out,
  output logic                  Acc_latch,
  output logic                  out_latch,
  output logic                  busy,
  output logic                  halted,
  output logic [CNT_WIDTH-1:0]  instr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WAIT_STEP,
    S_HALT
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] ir;
  logic [CNT_WIDTH-1:0]  count;

  logic is_hlt;
  logic is_branch;
  logic br_taken;
  logic start;

  assign is_hlt    = (ir == '0);
  assign is_branch = |ir[6:4];
  assign start     = run && ((state == S_IDLE) || (state == S_HALT));

  // Branch resolution: only the highest-priority branch bit decides (BRA > BRZ > BRP)
  always_comb begin
    br_taken = 1'b0;
    if (ir[6])      br_taken = 1'b1;
    else if (ir[5]) br_taken = Z_flag;
    else if (ir[4]) br_taken = PZ_flag;
  end

  // Address/select outputs follow IR, so they are stable from DECODE through EXEC
  assign RAM1_addr      = pc;
  assign RAM2_addr      = ir[ADDR_WIDTH-1:0];
  assign mux_switch_out = ir[8:7];
  assign busy           = (state == S_FETCH) || (state == S_DECODE) ||
                          (state == S_EXEC)  || (state == S_WAIT_STEP);
  assign halted         = (state == S_HALT);
  assign instr_count    = count;

  // State register
  always_ff @(posedge timer555 or negedge reset_count_n) begin
    if (!reset_count_n) state <= S_IDLE;
    else                state <= state_nxt;
  end

  // Next-state and strobe decode; strobes depend on registered state/IR only
  always_comb begin
    state_nxt = state;
    RAM2_we   = 1'b0;
    Acc_latch = 1'b0;
    out_latch = 1'b0;
    case (state)
      S_IDLE, S_HALT: begin
        if (run) state_nxt = S_FETCH;
      end
      S_FETCH: state_nxt = S_DECODE;
      S_DECODE: begin
        if (is_hlt) state_nxt = S_HALT;
        else        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (!is_branch) begin
          if (ir[11])      RAM2_we   = 1'b1;
          else if (ir[10]) Acc_latch = 1'b1;
          else if (ir[9])  out_latch = 1'b1;
        end
        state_nxt = step_mode ? S_WAIT_STEP : S_FETCH;
      end
      S_WAIT_STEP: begin
        if (step || !step_mode) state_nxt = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Program counter, instruction register and saturating instruction counter
  always_ff @(posedge timer555 or negedge reset_count_n) begin
    if (!reset_count_n) begin
      pc    <= '0;
      ir    <= '0;
      count <= '0;
    end else if (start) begin
      pc    <= '0;
      count <= '0;
    end else if (state == S_FETCH) begin
      ir <= RAM1_out;
    end else if (state == S_EXEC) begin
      pc <= br_taken ? ir[ADDR_WIDTH-1:0] : pc + 1'b1;
      if (count != '1) count <= count + 1'b1;
    end
  end

endmodule

// File: doc/r52_sequencer.md
# r52_sequencer

Fetch/decode/execute controller for the R52 accumulator machine. It replaces manual stepping through the RAM1_button with an automatic sequencer. It owns the program counter, addresses RAM1 (the 16 × 12-bit program store), latches each instruction and decodes it. It then drives the datapath strobes (Acc_latch, RAM2 write, output latch, mux select) and resolves branches from Z_flag/PZ_flag.

## Interface
Parameters:
- ADDR_WIDTH, 4, program-counter and RAM1/RAM2 address width
- DATA_WIDTH, 12, instruction word width
- CNT_WIDTH, 8, executed-instruction counter width

Ports:
- timer555  in  1  clock; all state changes on rising edge
- reset_count_n  in  1  asynchronous, active-low reset
- run  in  1  start pulse (one cycle): PC←0 and begin execution
- step_mode  in  1  1 = pause after each instruction
- step  in  1  one-cycle pulse that releases one paused instruction
- RAM1_addr  out  ADDR_WIDTH  program address (= PC)
- RAM1_out  in  DATA_WIDTH  instruction; combinational read, valid in the same cycle
- Z_flag, PZ_flag  in  1  accumulator zero / non-negative flags from the datapath
- RAM2_addr  out  ADDR_WIDTH  data-memory address = IR[3:0]
- RAM2_we  out  1  one-cycle store strobe (Acc → RAM2)
- mux_switch_out  out  2  accumulator source select = IR[8:7]
- Acc_latch  out  1  one-cycle accumulator load strobe
- out_latch  out  1  one-cycle data_out load strobe
- busy  out  1  high in FETCH/DECODE/EXEC/WAIT_STEP
- halted  out  1  high in HALT
- instr_count  out  CNT_WIDTH  executed instructions, saturating

## Operation
- Encoding: IR[3:0] is the address.
  - IR[4] is BRP (branch if PZ), IR[5] is BRZ (branch if Z), IR[6] is BRA (unconditional branch).
  - IR[8:7] is the ALU source: 00 data_in, 01 add RAM2, 10 sub RAM2, 11 load RAM2.
  - IR[9] is OUT, IR[10] is ACC (write accumulator), IR[11] is STA.
  - IR = 12'h000 is HLT.
- Class decode, in priority order:
  - HLT.
  - Branch: any of IR[6:4] set. Among branch bits, BRA > BRZ > BRP. A branch issues no data strobe.
  - STA: RAM2_we only.
  - ACC: Acc_latch only.
  - OUT: out_latch only.
  - Any other pattern is a NOP.
- States: IDLE, FETCH, DECODE, EXEC, WAIT_STEP, HALT.
- IDLE: wait for run. On run: PC←0, instr_count←0, go to FETCH.
- FETCH: RAM1_addr=PC; IR←RAM1_out on the edge; go to DECODE.
- DECODE:
  - RAM2_addr=IR[3:0] and mux_switch_out=IR[8:7]; these hold stable through EXEC.
  - If IR is HLT: go to HALT. instr_count is not incremented.
  - Otherwise go to EXEC.
- EXEC:
  - Assert exactly one strobe for the decoded class.
  - Sample Z_flag/PZ_flag in this cycle; they reflect the accumulator after the previous instruction.
  - Branch taken: PC←IR[3:0]. Otherwise: PC←PC+1, with 15 wrapping to 0.
  - instr_count←instr_count+1, saturating at 2^CNT_WIDTH−1.
  - Next state is WAIT_STEP if step_mode=1, else FETCH.
- WAIT_STEP: on step go to FETCH. step_mode falling while waiting also goes to FETCH.
- HALT: halted=1, PC frozen. run restarts as from IDLE.
- run while busy is ignored. step outside WAIT_STEP is ignored.

## Timing
- Reset (asynchronous, immediate): state=IDLE, PC=0, IR=0, instr_count=0.
- Outputs in reset:
  - RAM1_addr=0, RAM2_addr=0, mux_switch_out=0.
  - RAM2_we=0, Acc_latch=0, out_latch=0.
  - busy=0, halted=0.
- Reset mid-EXEC drops the strobe in the same instant; no partial write is required to complete.
- All strobes are registered-state decodes of EXEC, high for exactly one timer555 period. The datapath captures them on the rising edge that ends EXEC.
- Throughput is 3 cycles per instruction with step_mode=0. run → first strobe is 3 edges (FETCH, DECODE, EXEC).
- mux_switch_out and RAM2_addr settle one full cycle (DECODE) before the Acc_latch/RAM2_we edge.
- A branch taken in EXEC is fetched in the next FETCH with no bubble beyond the normal 3 cycles.
- HLT: halted rises on the edge ending DECODE, 2 cycles after the HLT address is presented.

## Test plan
- Program [0]=12'h400 (ACC from data_in), [1]=12'h800 (STA 0), [2]=0; pulse run -> one Acc_latch in cycle 3, RAM2_we with RAM2_addr=0 in cycle 6, halted=1 after cycle 8, instr_count=2.
- [0]=12'h500 (SUB 0) with Acc=RAM2[0] so that Z=1, PZ=1; [1]=12'h018 (BRP 8) -> PC=8 after EXEC; repeat with PZ=0 -> PC=2.
- [15]=12'h200 (OUT), PC reaching 15 -> out_latch pulse, then PC wraps to 0 and the fetch continues at address 0.
- step_mode=1, three-instruction program -> busy held in WAIT_STEP; each step pulse yields exactly one strobe; step while in FETCH is ignored.
- Assert reset_count_n low during EXEC of STA -> RAM2_we falls immediately, all outputs at reset values; after release, run restarts at PC=0.
- Tight loop [0]=12'h040 (BRA 0) for 300 instructions -> instr_count saturates at 255 and never wraps.
